// File: rtl/memory_axi_master_if.sv
// rtl/memory_axi_master_if.sv - AXI4-Lite bus bundle between the load/store master and the data-memory slave

interface memory_axi_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   o_AWADDR;
    logic                    o_AWVALID;
    logic                    i_AWREADY;
    logic [DATA_WIDTH-1:0]   o_WDATA;
    logic [DATA_WIDTH/8-1:0] o_WSTRB;
    logic                    o_WVALID;
    logic                    i_WREADY;
    logic [1:0]              i_BRESP;
    logic                    i_BVALID;
    logic                    o_BREADY;
    logic [ADDR_WIDTH-1:0]   o_ARADDR;
    logic                    o_ARVALID;
    logic                    i_ARREADY;
    logic [DATA_WIDTH-1:0]   i_RDATA;
    logic [1:0]              i_RRESP;
    logic                    i_RVALID;
    logic                    o_RREADY;

    modport master (
        output o_AWADDR, o_AWVALID, input i_AWREADY,
        output o_WDATA, o_WSTRB, o_WVALID, input i_WREADY,
        input  i_BRESP, i_BVALID, output o_BREADY,
        output o_ARADDR, o_ARVALID, input i_ARREADY,
        input  i_RDATA, i_RRESP, i_RVALID, output o_RREADY
    );

    modport slave (
        input  o_AWADDR, o_AWVALID, output i_AWREADY,
        input  o_WDATA, o_WSTRB, o_WVALID, output i_WREADY,
        output i_BRESP, i_BVALID, input o_BREADY,
        input  o_ARADDR, o_ARVALID, output i_ARREADY,
        output i_RDATA, i_RRESP, i_RVALID, input o_RREADY
    );
endinterface

// File: rtl/memory_axi_master.sv
// rtl/memory_axi_master.sv - one CPU load/store to one AXI4-Lite transaction with sizing, strobes and errors

module memory_axi_master #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int STATE_WIDTH = 3
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset_n,
    input  logic                   i_Load_Request,
    input  logic                   i_Store_Request,
    input  logic [ADDR_WIDTH-1:0]  i_Address,
    input  logic [DATA_WIDTH-1:0]  i_Store_Data,
    input  logic [2:0]             i_Funct3,
    output logic [DATA_WIDTH-1:0]  o_Load_Data,
    output logic                   o_Done,
    output logic                   o_Error,
    output logic [STATE_WIDTH-1:0] o_State,
    memory_axi_master_if.master    axi
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(NBYTES);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_RD_ADDR      = 3'd1,
        S_RD_DATA      = 3'd2,
        S_WR_ADDR_DATA = 3'd3,
        S_WR_RESP      = 3'd4,
        S_DONE         = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NBYTES-1:0]     wstrb_q, wstrb_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [OFF_W-1:0]      offset_q, offset_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] load_data_q, load_data_d;

    logic                  store_sel;
    logic                  legal;
    logic                  misalign;
    int                    size_bytes;
    logic [DATA_WIDTH-1:0] wdata_n;
    logic [NBYTES-1:0]     strb_base;
    logic [DATA_WIDTH-1:0] lane;
    logic [DATA_WIDTH-1:0] load_ext;
    int                    nbits;
    logic                  sbit;

    // Request decode: store wins over load; 64-bit accesses only exist on a 64-bit bus.
    always_comb begin
        store_sel  = i_Store_Request;
        size_bytes = 1 << i_Funct3[1:0];
        legal      = 1'b0;
        if (store_sel) begin
            legal = !i_Funct3[2] && ((i_Funct3[1:0] != 2'b11) || (DATA_WIDTH == 64));
        end else begin
            case (i_Funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                3'b011, 3'b110:                         legal = (DATA_WIDTH == 64);
                default:                                legal = 1'b0;
            endcase
        end
        case (i_Funct3[1:0])
            2'b01:   misalign = i_Address[0];
            2'b10:   misalign = |i_Address[1:0];
            2'b11:   misalign = |i_Address[2:0];
            default: misalign = 1'b0;
        endcase
    end

    // Store data is replicated across every lane so the strobes alone select the bytes.
    always_comb begin
        wdata_n   = '0;
        strb_base = '0;
        for (int i = 0; i < NBYTES; i++) begin
            wdata_n[i*8 +: 8] = i_Store_Data[8*(i & (size_bytes - 1)) +: 8];
            strb_base[i]      = (i < size_bytes);
        end
    end

    always_comb begin
        lane = axi.i_RDATA >> {offset_q, 3'b000};
        case (funct3_q[1:0])
            2'b00:   begin nbits = 8;          sbit = lane[7];            end
            2'b01:   begin nbits = 16;         sbit = lane[15];           end
            2'b10:   begin nbits = 32;         sbit = lane[31];           end
            default: begin nbits = DATA_WIDTH; sbit = lane[DATA_WIDTH-1]; end
        endcase
        sbit     = sbit & ~funct3_q[2];
        load_ext = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            load_ext[i] = (i < nbits) ? lane[i] : sbit;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        funct3_d    = funct3_q;
        offset_d    = offset_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        err_d       = err_q;
        load_data_d = load_data_q;

        case (state_q)
            S_IDLE: begin
                if (i_Store_Request || i_Load_Request) begin
                    funct3_d = i_Funct3;
                    offset_d = i_Address[OFF_W-1:0];
                    if (!legal || misalign) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d  = 1'b0;
                        addr_d = {i_Address[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                        if (store_sel) begin
                            wdata_d   = wdata_n;
                            wstrb_d   = strb_base << i_Address[OFF_W-1:0];
                            aw_done_d = 1'b0;
                            w_done_d  = 1'b0;
                            state_d   = S_WR_ADDR_DATA;
                        end else begin
                            state_d = S_RD_ADDR;
                        end
                    end
                end
            end
            S_RD_ADDR: begin
                if (axi.i_ARREADY) begin
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (axi.i_RVALID) begin
                    load_data_d = load_ext;
                    err_d       = (axi.i_RRESP != 2'b00);
                    state_d     = S_DONE;
                end
            end
            S_WR_ADDR_DATA: begin
                aw_done_d = aw_done_q | axi.i_AWREADY;
                w_done_d  = w_done_q | axi.i_WREADY;
                if (aw_done_d && w_done_d) begin
                    state_d = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (axi.i_BVALID) begin
                    err_d   = (axi.i_BRESP != 2'b00);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            funct3_q    <= '0;
            offset_q    <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            err_q       <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            funct3_q    <= funct3_d;
            offset_q    <= offset_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            err_q       <= err_d;
            load_data_q <= load_data_d;
        end
    end

    // Handshake outputs decode straight from state so a reset drops them in the same instant.
    assign axi.o_ARVALID = (state_q == S_RD_ADDR);
    assign axi.o_RREADY  = (state_q == S_RD_DATA);
    assign axi.o_AWVALID = (state_q == S_WR_ADDR_DATA) && !aw_done_q;
    assign axi.o_WVALID  = (state_q == S_WR_ADDR_DATA) && !w_done_q;
    assign axi.o_BREADY  = (state_q == S_WR_RESP);
    assign axi.o_ARADDR  = addr_q;
    assign axi.o_AWADDR  = addr_q;
    assign axi.o_WDATA   = wdata_q;
    assign axi.o_WSTRB   = wstrb_q;

    assign o_Load_Data = load_data_q;
    assign o_Done      = (state_q == S_DONE);
    assign o_Error     = (state_q == S_DONE) && err_q;
    assign o_State     = STATE_WIDTH'(state_q);
endmodule

// File: tb/tb_memory_axi_master.sv
// tb/tb_memory_axi_master.sv - scoreboard bench for memory_axi_master with a randomized AXI4-Lite slave

module tb_memory_axi_master;
    logic        clk;
    logic        rst_n;
    logic        load_req;
    logic        store_req;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [2:0]  funct3;
    logic [31:0] load_data;
    logic        done;
    logic        err;
    logic [2:0]  state;

    memory_axi_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    memory_axi_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STATE_WIDTH(3)) dut (
        .i_Clock         (clk),
        .i_Reset_n       (rst_n),
        .i_Load_Request  (load_req),
        .i_Store_Request (store_req),
        .i_Address       (addr),
        .i_Store_Data    (sdata),
        .i_Funct3        (funct3),
        .o_Load_Data     (load_data),
        .o_Done          (done),
        .o_Error         (err),
        .o_State         (state),
        .axi             (axi)
    );

    typedef struct {
        logic        err;
        logic [31:0] ldata;
        bit          rd;
        bit          wr;
        logic [31:0] baddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    int          req_cyc = 0;
    logic [31:0] model_ldata = 0;

    int          cfg_ar = 0, cfg_r = 0, cfg_aw = 0, cfg_w = 0, cfg_b = 0;
    logic [31:0] cfg_rdata = 0;
    logic [1:0]  cfg_rresp = 0, cfg_bresp = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Slave channels: each READY/VALID is raised after a configurable number of waiting cycles.
    initial begin
        int n = 0;
        axi.i_ARREADY = 0;
        forever begin
            @(negedge clk);
            if (axi.o_ARVALID) begin
                if (n >= cfg_ar) axi.i_ARREADY = 1; else begin axi.i_ARREADY = 0; n++; end
            end else begin axi.i_ARREADY = 0; n = 0; end
        end
    end
    initial begin
        int n = 0;
        axi.i_RVALID = 0; axi.i_RDATA = 0; axi.i_RRESP = 0;
        forever begin
            @(negedge clk);
            if (axi.o_RREADY && n >= cfg_r) begin
                axi.i_RVALID = 1; axi.i_RDATA = cfg_rdata; axi.i_RRESP = cfg_rresp;
            end else begin
                axi.i_RVALID = 0; axi.i_RDATA = $urandom; axi.i_RRESP = 2'($urandom);
                n = axi.o_RREADY ? n + 1 : 0;
            end
        end
    end
    initial begin
        int n = 0;
        axi.i_AWREADY = 0;
        forever begin
            @(negedge clk);
            if (axi.o_AWVALID) begin
                if (n >= cfg_aw) axi.i_AWREADY = 1; else begin axi.i_AWREADY = 0; n++; end
            end else begin axi.i_AWREADY = 0; n = 0; end
        end
    end
    initial begin
        int n = 0;
        axi.i_WREADY = 0;
        forever begin
            @(negedge clk);
            if (axi.o_WVALID) begin
                if (n >= cfg_w) axi.i_WREADY = 1; else begin axi.i_WREADY = 0; n++; end
            end else begin axi.i_WREADY = 0; n = 0; end
        end
    end
    initial begin
        int n = 0;
        axi.i_BVALID = 0; axi.i_BRESP = 0;
        forever begin
            @(negedge clk);
            if (axi.o_BREADY && n >= cfg_b) begin
                axi.i_BVALID = 1; axi.i_BRESP = cfg_bresp;
            end else begin
                axi.i_BVALID = 0; axi.i_BRESP = 2'($urandom);
                n = axi.o_BREADY ? n + 1 : 0;
            end
        end
    end

    // Monitor: checks bus beats against the head expectation and retires it on o_Done.
    initial begin
        bit ar_seen = 0, aw_seen = 0, ar_pend = 0, aw_pend = 0, w_pend = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                ar_seen = 0; aw_seen = 0; ar_pend = 0; aw_pend = 0; w_pend = 0;
                continue;
            end
            if (ar_pend) chk("arvalid_hold", 64'(axi.o_ARVALID), 64'd1);
            if (aw_pend) chk("awvalid_hold", 64'(axi.o_AWVALID), 64'd1);
            if (w_pend)  chk("wvalid_hold", 64'(axi.o_WVALID), 64'd1);
            ar_pend = axi.o_ARVALID && !axi.i_ARREADY;
            aw_pend = axi.o_AWVALID && !axi.i_AWREADY;
            w_pend  = axi.o_WVALID && !axi.i_WREADY;
            if (axi.o_ARVALID) ar_seen = 1;
            if (axi.o_AWVALID) aw_seen = 1;
            if (sbq.size() != 0) begin
                if (axi.o_ARVALID && axi.i_ARREADY) chk("araddr", 64'(axi.o_ARADDR), 64'(sbq[0].baddr));
                if (axi.o_AWVALID && axi.i_AWREADY) chk("awaddr", 64'(axi.o_AWADDR), 64'(sbq[0].baddr));
                if (axi.o_WVALID && axi.i_WREADY) begin
                    chk("wdata", 64'(axi.o_WDATA), 64'(sbq[0].wdata));
                    chk("wstrb", 64'(axi.o_WSTRB), 64'(sbq[0].wstrb));
                end
            end
            if (done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("error", 64'(err), 64'(e.err));
                    chk("load_data", 64'(load_data), 64'(e.ldata));
                    chk("ar_traffic", 64'(ar_seen), 64'(e.rd));
                    chk("aw_traffic", 64'(aw_seen), 64'(e.wr));
                    if (e.lat != 0) chk("latency", 64'(cyc - req_cyc), 64'(e.lat));
                end
                done_cnt++;
                ar_seen = 0; aw_seen = 0;
            end
        end
    end

    task automatic run(input bit st, input bit ld, input logic [31:0] a, input logic [2:0] f3,
                       input logic [31:0] sd, input logic [31:0] rd, input logic [1:0] rr,
                       input logic [1:0] br, input int d_ar, input int d_r, input int d_aw,
                       input int d_w, input int d_b, input int lat);
        exp_t        e;
        int          sz, off, bits, target;
        bit          legal, mis;
        logic [31:0] v, mask, one;
        one = 32'd1;
        sz  = 1 << f3[1:0];
        off = a % 4;
        if (st) legal = (f3 <= 2);
        else    legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        mis = (a % sz) != 0;
        e = '{err: 0, ldata: 0, rd: 0, wr: 0, baddr: a & ~32'h3, wdata: 0, wstrb: 0, lat: lat};
        if (!legal || mis) begin
            e.err = 1;
        end else if (st) begin
            e.wr  = 1;
            e.err = (br != 0);
            for (int i = 0; i < 4; i++) begin
                e.wdata[8*i +: 8] = sd[8*(i % sz) +: 8];
                e.wstrb[i]        = (i >= off) && (i < off + sz);
            end
        end else begin
            e.rd  = 1;
            e.err = (rr != 0);
            bits  = 8 * sz;
            mask  = (one << bits) - 1;
            v     = (rd >> (8 * off)) & mask;
            if (!f3[2] && v[bits-1]) v = v | ~mask;
            model_ldata = v;
        end
        e.ldata = model_ldata;
        cfg_ar = d_ar; cfg_r = d_r; cfg_aw = d_aw; cfg_w = d_w; cfg_b = d_b;
        cfg_rdata = rd; cfg_rresp = rr; cfg_bresp = br;
        target = done_cnt + 1;
        sbq.push_back(e);
        @(negedge clk);
        store_req = st; load_req = ld; addr = a; funct3 = f3; sdata = sd;
        req_cyc = cyc;
        @(negedge clk);
        store_req = 0; load_req = 0; addr = $urandom; funct3 = 3'($urandom); sdata = $urandom;
        for (int t = 0; t < 300 && done_cnt < target; t++) @(negedge clk);
        if (done_cnt < target) begin
            total++; bad++;
            $display("FAIL done_timeout: got no o_Done expected one within 300 cycles");
            sbq.delete();
        end
    endtask

    initial begin
        int          ld_f3[5] = '{0, 1, 2, 4, 5};
        bit          st, ld;
        logic [2:0]  f3;
        logic [31:0] a;
        int          sz;
        rst_n = 0; load_req = 0; store_req = 0; addr = 0; sdata = 0; funct3 = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_valids", 64'({axi.o_ARVALID, axi.o_RREADY, axi.o_AWVALID, axi.o_WVALID, axi.o_BREADY}), 64'd0);
        chk("reset_done_err", 64'({done, err}), 64'd0);
        chk("reset_load_data", 64'(load_data), 64'd0);
        chk("reset_bus", {axi.o_ARADDR, axi.o_WDATA}, 64'd0);
        chk("reset_strb_aw", 64'({axi.o_AWADDR, axi.o_WSTRB}), 64'd0);
        @(negedge clk);
        rst_n = 1;

        run(0, 1, 32'h100, 3'b010, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 3);
        chk("t1_lw", 64'(load_data), 64'hDEADBEEF);
        run(0, 1, 32'h103, 3'b000, 0, 32'h80000000, 0, 0, 1, 2, 0, 0, 0, 0);
        chk("t2_lb", 64'(load_data), 64'hFFFFFF80);
        run(0, 1, 32'h103, 3'b100, 0, 32'h80000000, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t2_lbu", 64'(load_data), 64'h00000080);
        run(0, 1, 32'h102, 3'b101, 0, 32'h80000000, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t2_lhu", 64'(load_data), 64'h00008000);
        run(1, 0, 32'h2, 3'b000, 32'hAB, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        run(1, 0, 32'h2, 3'b001, 32'h1234, 0, 0, 0, 0, 0, 0, 3, 1, 0);
        run(1, 0, 32'h40, 3'b010, 32'h11223344, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        run(0, 1, 32'h101, 3'b001, 0, 32'h5555AAAA, 0, 0, 0, 0, 0, 0, 0, 1);
        run(1, 0, 32'h101, 3'b001, 32'h1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        run(0, 1, 32'h100, 3'b011, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        run(1, 0, 32'h200, 3'b010, 32'hCAFEF00D, 0, 0, 2'b10, 0, 0, 1, 1, 2, 0);
        run(0, 1, 32'h200, 3'b010, 0, 32'h0BADF00D, 0, 0, 0, 1, 0, 0, 0, 0);
        run(1, 1, 32'h10, 3'b010, 32'h600DD00D, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 3);

        // Abandon a read while the data phase is stalled.
        cfg_ar = 0; cfg_r = 50;
        @(negedge clk);
        load_req = 1; addr = 32'h44; funct3 = 3'b010;
        @(negedge clk);
        load_req = 0;
        for (int t = 0; t < 20 && state != 3'd2; t++) @(negedge clk);
        chk("rst_reach_rd_data", 64'(state), 64'd2);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_state", 64'(state), 64'd0);
        chk("rst_mid_ar_r", 64'({axi.o_ARVALID, axi.o_RREADY}), 64'd0);
        chk("rst_mid_load_data", 64'(load_data), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        model_ldata = 0;
        cfg_r = 0;

        for (int n = 0; n < 80; n++) begin
            st = 1'($urandom_range(0, 1));
            ld = st ? 1'($urandom_range(0, 1)) : 1'b1;
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
            else if (st) f3 = 3'($urandom_range(0, 2));
            else f3 = 3'(ld_f3[$urandom_range(0, 4)]);
            a  = 32'($urandom_range(0, 1023));
            sz = 1 << f3[1:0];
            if ($urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
            run(st, ld, a, f3, $urandom, $urandom,
                ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end

        repeat (3) @(negedge clk);
        chk("final_idle", 64'(state), 64'd0);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
